// File: rtl/spi_master_rx_fifo.sv
// SPI RX word FIFO: absorbs words from the RX shifter (no backpressure) and serves them over valid/ready.
// Optional occupancy-threshold interrupt is compiled in with `define SPI_RX_FIFO_THR_IRQ_EN.
module spi_master_rx_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int LOG_DEPTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr_i,
    input  logic                  wr_valid_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [LOG_DEPTH:0]    elements_o,
    output logic                  full_o,
    output logic                  overflow_o,
`ifdef SPI_RX_FIFO_THR_IRQ_EN
    input  logic [LOG_DEPTH:0]    thr_i,
    output logic                  thr_irq_o,
`endif
    input  logic                  ovf_clr_i
);

    localparam logic [LOG_DEPTH:0] DEPTH_CNT = (LOG_DEPTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [LOG_DEPTH:0]    r_wr_ptr;
    logic [LOG_DEPTH:0]    r_rd_ptr;
    logic [LOG_DEPTH:0]    r_count;
    logic                  r_full;
    logic                  r_ovf;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic                  w_pop;
    logic                  w_wr_acc;
    logic                  w_drop;
    logic [LOG_DEPTH:0]    w_wr_ptr_nxt;
    logic [LOG_DEPTH:0]    w_rd_ptr_nxt;
    logic [LOG_DEPTH:0]    w_count_nxt;
    logic [DATA_WIDTH-1:0] w_head_nxt;

    // Valid/ready: a pop happens only when rd_valid_o & rd_ready_i are both high at the clock edge;
    // rd_data_o holds steady while rd_valid_o=1 and no pop occurs.
    assign rd_valid_o = (r_wr_ptr != r_rd_ptr);
    assign w_pop      = rd_valid_o & rd_ready_i;
    assign w_wr_acc   = wr_valid_i & (~r_full | w_pop) & ~clr_i;
    assign w_drop     = wr_valid_i & r_full & ~w_pop;

    assign w_wr_ptr_nxt = r_wr_ptr + {{LOG_DEPTH{1'b0}}, w_wr_acc};
    assign w_rd_ptr_nxt = r_rd_ptr + {{LOG_DEPTH{1'b0}}, w_pop};
    assign w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

    // Next head comes straight from the write port when it lands in the slot being written now.
    assign w_head_nxt = (w_rd_ptr_nxt == r_wr_ptr) ? wr_data_i
                                                   : r_mem[w_rd_ptr_nxt[LOG_DEPTH-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[LOG_DEPTH-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_ovf     <= 1'b0;
            r_rd_data <= '0;
        end else if (clr_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == DEPTH_CNT);
            // A drop coinciding with ovf_clr_i keeps the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr_i) begin
                r_ovf <= 1'b0;
            end
            if (w_rd_ptr_nxt != w_wr_ptr_nxt) begin
                r_rd_data <= w_head_nxt;
            end
        end
    end

    assign elements_o = r_count;
    assign full_o     = r_full;
    assign overflow_o = r_ovf;
    assign rd_data_o  = r_rd_data;

`ifdef SPI_RX_FIFO_THR_IRQ_EN
    logic r_thr_irq;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_thr_irq <= 1'b0;
        end else if (clr_i) begin
            r_thr_irq <= 1'b0;
        end else begin
            r_thr_irq <= (thr_i != '0) && (r_count >= thr_i);
        end
    end

    assign thr_irq_o = r_thr_irq;
`endif

endmodule

// File: doc/spi_master_rx_fifo.md
Name: spi_master_rx_fifo

Overview:
- Buffers 32-bit words from the SPI RX shifter (data/data_valid) and presents them to the register/AXI read side through a valid/ready interface.
- The shifter has no backpressure, so this block absorbs rate mismatch.
- Drops words on overflow and records the drop in a sticky flag.
- Reports occupancy to the control/status logic.

Parameters:
- DATA_WIDTH, 32, word width.
- DEPTH, 8, number of entries; power of two, >= 2.
- LOG_DEPTH, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- clk  input  1  clock.
- rstn  input  1  reset; asynchronous, active-low.
- clr_i  input  1  synchronous flush: empties FIFO, clears overflow flag.
- wr_valid_i  input  1  write strobe from RX shifter (data_valid); single-cycle pulses.
- wr_data_i  input  DATA_WIDTH  write data from RX shifter.
- rd_valid_o  output  1  head entry available.
- rd_ready_i  input  1  consumer accepts head; pop on rd_valid_o & rd_ready_i.
- rd_data_o  output  DATA_WIDTH  head entry; stable while rd_valid_o=1 and no pop.
- elements_o  output  LOG_DEPTH+1  current occupancy, 0..DEPTH.
- full_o  output  1  elements_o == DEPTH.
- overflow_o  output  1  sticky: a write was dropped.
- ovf_clr_i  input  1  clears overflow_o.

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array.
  - Write pointer and read pointer, each LOG_DEPTH+1 bits; the MSB is the wrap bit.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
- Reset: pointers 0; elements_o=0; rd_valid_o=0; full_o=0; overflow_o=0; rd_data_o=0. Array contents are don't-care.
- Write accept: wr_valid_i & (~full | pop_this_cycle).
  - Data is stored at the write pointer; the write pointer increments modulo 2*DEPTH.
- Pop: rd_valid_o & rd_ready_i; the read pointer increments.
- Latency: no fall-through. A word written in cycle N is visible on rd_valid_o/rd_data_o in cycle N+1.
- rd_data_o is the array entry at the read pointer. When empty it holds the last-read value; the verification engineer must not check it while rd_valid_o=0.
- elements_o and full_o are registered and update the cycle after a write or pop:
  - write only: +1;
  - pop only: -1;
  - write+pop: unchanged.
- Full + wr_valid_i + pop in the same cycle: the write is accepted, occupancy stays DEPTH, and overflow_o is not set.
- Full + wr_valid_i without pop: the word is dropped, pointers are unchanged, and overflow_o=1 from the next cycle.
- Empty + rd_ready_i: no pop; rd_ready_i is ignored.
- overflow_o:
  - set by a drop;
  - cleared by ovf_clr_i or clr_i;
  - a drop in the same cycle as ovf_clr_i wins, so overflow_o stays 1.
- clr_i: next cycle pointers=0, elements_o=0, rd_valid_o=0, overflow_o=0.
  - A write in the same cycle as clr_i is discarded.
  - clr_i has priority over all other events.
- Async reset mid-stream: immediate return to reset values; the first word after reset is written to entry 0.
- Pointer wrap: after 2*DEPTH writes the pointers wrap to 0 with correct full/empty detection.

Optional Feature:
- Macro: SPI_RX_FIFO_THR_IRQ_EN.
- Defined: adds two ports.
  - thr_i  input  LOG_DEPTH+1  threshold.
  - thr_irq_o  output  1  registered, reset 0; level, not sticky.
  - thr_irq_o = 1 in the cycle after elements_o becomes >= thr_i with thr_i != 0. It is 0 whenever that condition is false, including after clr_i.
  - thr_i=0 disables the irq.
- Undefined: no thr_i or thr_irq_o ports; no extra logic.

Test Plan:
- Write 0xA5A5_0001..0xA5A5_0003 on consecutive cycles with rd_ready_i=0 -> elements_o=3, rd_valid_o=1 one cycle after the first write, rd_data_o=0xA5A5_0001. Then rd_ready_i=1 for 3 cycles -> reads 0001, 0002, 0003 in order; elements_o=0; rd_valid_o=0.
- Fill with 8 words (DEPTH=8), then a 9th write of 0xDEAD_BEEF -> full_o=1, overflow_o=1, elements_o=8. Drain -> 8 original words, no 0xDEAD_BEEF. Pulse ovf_clr_i -> overflow_o=0.
- Full, wr_valid_i=1 with data 0x1234_5678 and pop in the same cycle -> overflow_o stays 0, elements_o=8; 0x1234_5678 is read last.
- Stream 40 words continuously with rd_ready_i=1 -> every word read in order with 1-cycle latency, elements_o never exceeds 1, and pointer wrap (16) is exercised twice.
- 5 words queued, overflow_o=1, then clr_i=1 together with wr_valid_i=1 -> next cycle elements_o=0, rd_valid_o=0, overflow_o=0, and the concurrent word is lost. Assert rstn=0 mid-fill -> all outputs at reset values immediately.
- [SPI_RX_FIFO_THR_IRQ_EN] thr_i=4; write 4 words -> thr_irq_o rises the cycle after elements_o=4. Pop 1 -> thr_irq_o falls. thr_i=0 with FIFO full -> thr_irq_o=0.
